apb_requester: RTL and testbench

APB4 requester (master) FSM sitting directly upstream of the APB completer interface. It accepts single read/write commands from a local valid/ready request port, drives the APB SETUP/ACCESS phases, waits on pready, and returns read data plus error status on a one-cycle response strobe. A programmable access-phase timeout aborts transfers to a hung completer.

---
 rtl/apb_requester.sv | 175 +++++++++++++++++
 tb/tb_apb_requester.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// -----------------------------------------------------------------------------
// apb_requester
//   APB4 requester FSM. Takes single read/write commands from a local
//   valid/ready port, runs the APB SETUP and ACCESS phases, and returns the
//   read data with error status on a one-cycle response strobe. A programmable
//   access-phase timeout aborts transfers to a completer that never responds.
//
// Ports
//   pclk, preset         clock; synchronous active-high reset
//   req_valid/req_ready  request handshake (req_ready only in IDLE)
//   req_write, req_addr, req_wdata, req_strb, req_prot
//                        request fields, sampled only at the accept edge
//   resp_valid           one-cycle pulse per accepted request
//   resp_rdata           read data (0 for writes and timeouts)
//   resp_error           pslverr seen or timeout
//   resp_timeout         transfer aborted by timeout
//   paddr, pprot, psel, penable, pwrite, pwdata, pstrb
//                        APB requester outputs, all registered
//   pready, prdata, pslverr
//                        APB completer inputs, sampled only in ACCESS
// -----------------------------------------------------------------------------
module apb_requester #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [BYTES_PER_WORD-1:0] req_strb,
  input  logic [2:0]                req_prot,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_error,
  output logic                      resp_timeout,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [2:0]                pprot,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [BYTES_PER_WORD-1:0] pstrb,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Counter must hold values 0 .. TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]     paddr_nxt;
  logic [2:0]                pprot_nxt;
  logic                      psel_nxt, penable_nxt, pwrite_nxt;
  logic [DATA_WIDTH-1:0]     pwdata_nxt, resp_rdata_nxt;
  logic [BYTES_PER_WORD-1:0] pstrb_nxt;
  logic                      resp_valid_nxt, resp_error_nxt, resp_timeout_nxt;
  logic                      timeout_hit;

  assign req_ready = (state == IDLE) && !preset;

  // cnt counts completed wait cycles, so it equals CNT_LAST during the
  // TIMEOUT_CYCLES-th ACCESS cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; without this the tool infers latches.
    state_nxt        = state;
    cnt_nxt          = cnt;
    paddr_nxt        = paddr;
    pprot_nxt        = pprot;
    psel_nxt         = psel;
    penable_nxt      = penable;
    pwrite_nxt       = pwrite;
    pwdata_nxt       = pwdata;
    pstrb_nxt        = pstrb;
    resp_valid_nxt   = 1'b0;
    resp_rdata_nxt   = resp_rdata;
    resp_error_nxt   = resp_error;
    resp_timeout_nxt = resp_timeout;

    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          paddr_nxt   = req_addr;
          pprot_nxt   = req_prot;
          pwrite_nxt  = req_write;
          // Reads drive zero data/strobes so the bus carries no stale write data.
          pwdata_nxt  = req_write ? req_wdata : '0;
          pstrb_nxt   = req_write ? req_strb  : '0;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          state_nxt   = SETUP;
        end
      end

      SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = ACCESS;
      end

      ACCESS: begin
        // pready takes priority over a timeout firing in the same cycle.
        if (pready) begin
          psel_nxt         = 1'b0;
          penable_nxt      = 1'b0;
          resp_valid_nxt   = 1'b1;
          resp_rdata_nxt   = pwrite ? '0 : prdata;
          resp_error_nxt   = pslverr;
          resp_timeout_nxt = 1'b0;
          state_nxt        = IDLE;
        end else if (timeout_hit) begin
          psel_nxt         = 1'b0;
          penable_nxt      = 1'b0;
          resp_valid_nxt   = 1'b1;
          resp_rdata_nxt   = '0;
          resp_error_nxt   = 1'b1;
          resp_timeout_nxt = 1'b1;
          state_nxt        = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (preset) begin
      state        <= IDLE;
      cnt          <= '0;
      paddr        <= '0;
      pprot        <= '0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      pwdata       <= '0;
      pstrb        <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_error   <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      paddr        <= paddr_nxt;
      pprot        <= pprot_nxt;
      psel         <= psel_nxt;
      penable      <= penable_nxt;
      pwrite       <= pwrite_nxt;
      pwdata       <= pwdata_nxt;
      pstrb        <= pstrb_nxt;
      resp_valid   <= resp_valid_nxt;
      resp_rdata   <= resp_rdata_nxt;
      resp_error   <= resp_error_nxt;
      resp_timeout <= resp_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// -----------------------------------------------------------------------------
// tb_apb_requester
//   Directed bench for apb_requester (default parameters: 32-bit data,
//   10-bit address, TIMEOUT_CYCLES = 16). Inputs change and outputs are
//   sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        preset;
  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        resp_valid, resp_error, resp_timeout;
  logic [31:0] resp_rdata;
  logic [9:0]  paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Results of the most recent monitor() window.
  int          m_psel_cyc, m_pen_cyc, m_resp_cnt;
  logic [31:0] m_rdata;
  logic        m_err, m_to, m_unstable;
  logic [9:0]  m_paddr;
  logic [2:0]  m_pprot;
  logic        m_pwrite;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;

  localparam logic [31:0] NOISE = 32'hA5A5_5A5A;

  always #5 pclk = ~pclk;

  apb_requester dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .resp_timeout(resp_timeout),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Presents one request and returns 1 ns after the accept edge (DUT in SETUP).
  // Request fields are then scrambled to show they are not re-sampled.
  task automatic issue(input logic w, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    logic ok;
    logic accepted;
    accepted  = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a;
    req_wdata = d;    req_strb  = s; req_prot = p;
    for (int i = 0; i < 20 && !accepted; i++) begin
      ok = req_ready;
      tick();
      if (ok) accepted = 1'b1;
    end
    req_valid = 1'b0; req_write = ~w; req_addr = ~a;
    req_wdata = ~d;   req_strb  = ~s; req_prot = ~p;
    total_cnt++;
    if (accepted !== 1'b1) $display("FAIL accept: got %b want 1", accepted);
    else pass_cnt++;
  endtask

  // Observes `budget` cycles starting in SETUP. pready rises on ACCESS cycle
  // `ready_at` (0 = never) unless `tie` holds it high throughout.
  task automatic monitor(input int ready_at, input logic tie, input logic err,
                         input logic [31:0] rd, input int budget);
    int  acc;
    logic first;
    acc = 0; first = 1'b1;
    m_psel_cyc = 0; m_pen_cyc = 0; m_resp_cnt = 0; m_unstable = 1'b0;
    m_rdata = 'x; m_err = 1'bx; m_to = 1'bx;
    for (int i = 0; i < budget; i++) begin
      if (psel) begin
        m_psel_cyc++;
        if (first) begin
          m_paddr = paddr; m_pprot = pprot; m_pwrite = pwrite;
          m_pwdata = pwdata; m_pstrb = pstrb; first = 1'b0;
        end else if (paddr !== m_paddr || pprot !== m_pprot || pwrite !== m_pwrite
                     || pwdata !== m_pwdata || pstrb !== m_pstrb) begin
          m_unstable = 1'b1;
        end
      end
      if (penable) m_pen_cyc++;
      if (resp_valid) begin
        m_resp_cnt++;
        m_rdata = resp_rdata; m_err = resp_error; m_to = resp_timeout;
      end
      if (psel && penable) acc++;
      pready  = tie || (ready_at != 0 && psel && penable && acc == ready_at);
      prdata  = pready ? rd : NOISE;
      pslverr = err && pready;
      tick();
    end
    pready = 1'b0; pslverr = 1'b0; prdata = NOISE;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({psel, penable, resp_valid, req_ready} !== 4'b0000)
      $display("FAIL reset_ctrl: psel/pen/rv/rr got %b want 0000",
               {psel, penable, resp_valid, req_ready});
    else pass_cnt++;
    total_cnt++;
    if ({paddr, pprot, pwrite, pwdata, pstrb} !== '0)
      $display("FAIL reset_bus: paddr=%0d pprot=%0d pwdata=%0d got nonzero want 0",
               paddr, pprot, pwdata);
    else pass_cnt++;
    total_cnt++;
    if ({resp_rdata, resp_error, resp_timeout} !== '0)
      $display("FAIL reset_resp: rdata=%0d err=%b to=%b want 0", resp_rdata,
               resp_error, resp_timeout);
    else pass_cnt++;
    preset = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_zero_wait_write();
    pready = 1'b1;
    issue(1'b1, 10'd122, 32'd2772003, 4'b1111, 3'b110);
    monitor(1, 1'b1, 1'b0, NOISE, 6);
    total_cnt++;
    if (m_psel_cyc !== 2 || m_pen_cyc !== 1)
      $display("FAIL zw_phases: psel=%0d pen=%0d want 2 1", m_psel_cyc, m_pen_cyc);
    else pass_cnt++;
    total_cnt++;
    if (m_paddr !== 10'd122 || m_pprot !== 3'b110 || m_pwrite !== 1'b1 ||
        m_pwdata !== 32'd2772003 || m_pstrb !== 4'b1111)
      $display("FAIL zw_bus: addr=%0d prot=%b wr=%b wdata=%0d strb=%b want 122 110 1 2772003 1111",
               m_paddr, m_pprot, m_pwrite, m_pwdata, m_pstrb);
    else pass_cnt++;
    total_cnt++;
    if (m_resp_cnt !== 1 || m_rdata !== 32'd0 || m_err !== 1'b0 || m_to !== 1'b0)
      $display("FAIL zw_resp: cnt=%0d rdata=%0d err=%b to=%b want 1 0 0 0",
               m_resp_cnt, m_rdata, m_err, m_to);
    else pass_cnt++;
    total_cnt++;
    if (m_unstable !== 1'b0) $display("FAIL zw_stable: got %b want 0", m_unstable);
    else pass_cnt++;
  endtask

  task automatic test_wait_read();
    issue(1'b0, 10'd125, 32'hFFFF_FFFF, 4'b1111, 3'b100);
    monitor(4, 1'b0, 1'b0, 32'd2772003, 10);
    total_cnt++;
    if (m_psel_cyc !== 5 || m_pen_cyc !== 4)
      $display("FAIL wr_phases: psel=%0d pen=%0d want 5 4", m_psel_cyc, m_pen_cyc);
    else pass_cnt++;
    total_cnt++;
    if (m_paddr !== 10'd125 || m_pprot !== 3'b100 || m_pwrite !== 1'b0 ||
        m_pwdata !== 32'd0 || m_pstrb !== 4'b0000 || m_unstable !== 1'b0)
      $display("FAIL wr_bus: addr=%0d prot=%b wr=%b wdata=%0d strb=%b unst=%b want 125 100 0 0 0000 0",
               m_paddr, m_pprot, m_pwrite, m_pwdata, m_pstrb, m_unstable);
    else pass_cnt++;
    total_cnt++;
    if (m_resp_cnt !== 1 || m_rdata !== 32'd2772003 || m_err !== 1'b0 || m_to !== 1'b0)
      $display("FAIL wr_resp: cnt=%0d rdata=%0d err=%b to=%b want 1 2772003 0 0",
               m_resp_cnt, m_rdata, m_err, m_to);
    else pass_cnt++;
  endtask

  task automatic test_slave_error();
    issue(1'b1, 10'd7, 32'h1234_5678, 4'b0011, 3'b000);
    monitor(1, 1'b0, 1'b1, NOISE, 6);
    total_cnt++;
    if (m_resp_cnt !== 1 || m_err !== 1'b1 || m_to !== 1'b0 || m_rdata !== 32'd0)
      $display("FAIL slverr_resp: cnt=%0d err=%b to=%b rdata=%0d want 1 1 0 0",
               m_resp_cnt, m_err, m_to, m_rdata);
    else pass_cnt++;
    total_cnt++;
    if (m_pwdata !== 32'h1234_5678 || m_pstrb !== 4'b0011)
      $display("FAIL slverr_bus: wdata=%h strb=%b want 12345678 0011", m_pwdata, m_pstrb);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    issue(1'b0, 10'd300, 32'd0, 4'b0000, 3'b001);
    monitor(0, 1'b0, 1'b0, NOISE, 22);
    total_cnt++;
    if (m_psel_cyc !== 17 || m_pen_cyc !== 16)
      $display("FAIL to_phases: psel=%0d pen=%0d want 17 16", m_psel_cyc, m_pen_cyc);
    else pass_cnt++;
    total_cnt++;
    if (m_resp_cnt !== 1 || m_err !== 1'b1 || m_to !== 1'b1 || m_rdata !== 32'd0)
      $display("FAIL to_resp: cnt=%0d err=%b to=%b rdata=%0d want 1 1 1 0",
               m_resp_cnt, m_err, m_to, m_rdata);
    else pass_cnt++;
    // pready on the 16th ACCESS cycle beats the timeout.
    issue(1'b0, 10'd301, 32'd0, 4'b0000, 3'b001);
    monitor(16, 1'b0, 1'b0, 32'hCAFE_F00D, 22);
    total_cnt++;
    if (m_pen_cyc !== 16 || m_resp_cnt !== 1 || m_err !== 1'b0 || m_to !== 1'b0 ||
        m_rdata !== 32'hCAFE_F00D)
      $display("FAIL to_edge: pen=%0d cnt=%0d err=%b to=%b rdata=%h want 16 1 0 0 cafef00d",
               m_pen_cyc, m_resp_cnt, m_err, m_to, m_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_transfer();
    int rv;
    issue(1'b1, 10'd55, 32'd99, 4'b1111, 3'b010);
    tick(); tick();   // now in the 2nd ACCESS cycle, pready low
    total_cnt++;
    if ({psel, penable} !== 2'b11)
      $display("FAIL mid_access: psel/pen got %b want 11", {psel, penable});
    else pass_cnt++;
    preset = 1'b1;
    tick();
    total_cnt++;
    if ({psel, penable, resp_valid, req_ready} !== 4'b0000)
      $display("FAIL mid_reset: psel/pen/rv/rr got %b want 0000",
               {psel, penable, resp_valid, req_ready});
    else pass_cnt++;
    preset = 1'b0;
    #1;
    rv = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) rv++;
      tick();
    end
    total_cnt++;
    if (req_ready !== 1'b1 || rv !== 0)
      $display("FAIL mid_after: ready=%b resp_pulses=%0d want 1 0", req_ready, rv);
    else pass_cnt++;
    issue(1'b1, 10'd56, 32'd4242, 4'b1010, 3'b011);
    monitor(1, 1'b0, 1'b0, NOISE, 6);
    total_cnt++;
    if (m_resp_cnt !== 1 || m_err !== 1'b0 || m_paddr !== 10'd56 || m_pwdata !== 32'd4242)
      $display("FAIL mid_next: cnt=%0d err=%b addr=%0d wdata=%0d want 1 0 56 4242",
               m_resp_cnt, m_err, m_paddr, m_pwdata);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] addrs [3];
    logic [9:0] seen  [3];
    int  acc_cyc [3];
    int  n, setups, rv, psel_cyc;
    logic accept_now;
    addrs[0] = 10'h011; addrs[1] = 10'h022; addrs[2] = 10'h3FF;
    n = 0; setups = 0; rv = 0; psel_cyc = 0;
    pready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addrs[0];
    req_wdata = 32'd1; req_strb = 4'hF; req_prot = 3'b000;
    for (int i = 0; i < 15; i++) begin
      if (psel) psel_cyc++;
      if (psel && !penable && setups < 3) begin
        seen[setups] = paddr; setups++;
      end
      if (resp_valid) rv++;
      accept_now = req_valid && req_ready;
      tick();
      if (accept_now && n < 3) begin
        acc_cyc[n] = i; n++;
        if (n < 3) begin
          req_addr = addrs[n]; req_wdata = 32'(n + 1);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    pready = 1'b0;
    req_valid = 1'b0;
    total_cnt++;
    if (n !== 3 || acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3)
      $display("FAIL b2b_accept: n=%0d gaps=%0d,%0d want 3 3,3", n,
               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    else pass_cnt++;
    total_cnt++;
    if (rv !== 3 || psel_cyc !== 6)
      $display("FAIL b2b_resp: pulses=%0d psel_cycles=%0d want 3 6", rv, psel_cyc);
    else pass_cnt++;
    total_cnt++;
    if (setups !== 3 || seen[0] !== addrs[0] || seen[1] !== addrs[1] || seen[2] !== addrs[2])
      $display("FAIL b2b_addr: n=%0d got %h %h %h want 011 022 3ff", setups,
               seen[0], seen[1], seen[2]);
    else pass_cnt++;
  endtask

  initial begin
    preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0;
    pready = 1'b0; prdata = NOISE; pslverr = 1'b0;
    #1;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slave_error();
    test_timeout();
    test_reset_mid_transfer();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
